if_fetch_queue: RTL

- Parametrised successor to the single-register fetch stage. Decouples PC generation from decode with a QDEPTH-entry instruction queue and a credit-limited, pipelined instruction-memory request/response interface.
- Handles branch redirects by flushing the queue and discarding stale in-flight responses.
- Sits between the branch-resolve redirect source (EX), instruction memory, and ID.

---
 rtl/if_fetch_queue.sv | 130 +++++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: credit-limited pipelined imem requests feeding a QDEPTH-entry queue to ID.
// Define IF_PERF_CNT_EN to add fetch/drop/stall performance counters.
module if_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            if_valid_out,
    input  logic            if_ready_in,
    output logic [XLEN-1:0] if_pc_out,
    output logic [XLEN-1:0] if_npc_out,
    output logic [XLEN-1:0] if_ir_out
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_drop_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int IW = $clog2(QDEPTH);

    typedef enum logic {RUN, FLUSH} mode_e;

    logic [XLEN-1:0] fetch_pc, resp_pc;
    logic [CW-1:0]   count, outstanding, drop_cnt;
    logic [IW-1:0]   rd_ptr, wr_ptr;
    logic [XLEN-1:0] pc_mem [QDEPTH];
    logic [XLEN-1:0] ir_mem [QDEPTH];

    mode_e         mode;
    logic [CW+1:0] budget;
    logic          credit, req_fire, resp_push, resp_drop, resp_tracked, pop;
    logic [CW:0]   redirect_drop;

    assign mode   = (drop_cnt != '0) ? FLUSH : RUN;
    assign budget = {2'b00, count} + {2'b00, outstanding} + {2'b00, drop_cnt};
    assign credit = budget < (CW+2)'(QDEPTH);

    assign imem_req_valid = !rst && !redirect_valid && credit;
    assign imem_req_addr  = {fetch_pc[XLEN-1:2], 2'b00};
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is only ours if something is actually in flight; stray ones are ignored.
    assign resp_tracked = imem_resp_valid && (drop_cnt != '0 || outstanding != '0);
    assign resp_drop    = imem_resp_valid && (mode == FLUSH || (redirect_valid && outstanding != '0));
    assign resp_push    = imem_resp_valid && mode == RUN && outstanding != '0 && !redirect_valid;

    assign if_valid_out = !rst && count != '0;
    assign pop          = if_valid_out && if_ready_in && !redirect_valid;
    assign if_pc_out    = pc_mem[rd_ptr];
    assign if_npc_out   = pc_mem[rd_ptr] + XLEN'(4);
    assign if_ir_out    = ir_mem[rd_ptr];

    // Everything still in flight at a redirect belongs to the old stream and must be discarded.
    assign redirect_drop = {1'b0, drop_cnt} + {1'b0, outstanding} - (CW+1)'(resp_tracked);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_pc;
            resp_pc     <= redirect_pc;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= CW'(redirect_drop);
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
            if (resp_push) begin
                resp_pc <= resp_pc + XLEN'(4);
                wr_ptr  <= wr_ptr + IW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + IW'(1);
            if (resp_drop) drop_cnt <= drop_cnt - CW'(1);
            count       <= count + CW'(resp_push) - CW'(pop);
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_push);
        end
    end

    // NOTE: queue storage has no reset; count gates the head outputs so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (resp_push) begin
            pc_mem[wr_ptr] <= resp_pc;
            ir_mem[wr_ptr] <= imem_resp_data;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_drop_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (req_fire) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (resp_drop) perf_drop_cnt <= perf_drop_cnt + 32'd1;
            if (if_valid_out && !if_ready_in) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_resp_valid && outstanding == '0 && drop_cnt == '0));
            assert (!(resp_push && count == CW'(QDEPTH)));
        end
    end
`endif

endmodule
